// File: rtl/apb_slave_mem_responder_pkg.sv
// Shared APB types and default widths for the slave-side memory responder.
package apb_slave_mem_responder_pkg;

    localparam int ADDRESS_WIDTH     = 32;
    localparam int DATA_WIDTH        = 32;
    localparam int MEMORY_WIDTH      = 8;
    localparam int SLAVE_MEMORY_SIZE = 12;

    typedef enum bit {
        SLV_OKAY  = 1'b0,
        SLV_ERROR = 1'b1
    } slave_error_e;

    typedef enum bit {
        TX_READ  = 1'b0,
        TX_WRITE = 1'b1
    } tx_type_e;

    typedef enum bit {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slave_state_e;

endpackage

// File: rtl/apb_slave_byte_memory.sv
// Byte-organised local memory: one registered word read port and one
// byte-strobed word write port, lanes little-endian.
module apb_slave_byte_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 12 * 1024,
    parameter int MEM_AW     = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic [MEM_AW-1:0]       raddr,
    output logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    we,
    input  logic [MEM_AW-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb
);
    import apb_slave_mem_responder_pkg::*;

    localparam int LANES = DATA_WIDTH / MEMORY_WIDTH;

    logic [MEMORY_WIDTH-1:0] mem [MEM_BYTES];

    // The read register only moves on rd_en so it holds through a whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            for (int i = 0; i < LANES; i++) begin
                rdata[i*MEMORY_WIDTH +: MEMORY_WIDTH] <= mem[raddr + MEM_AW'(i)];
            end
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wstrb[i]) begin
                    mem[waddr + MEM_AW'(i)] <= wdata[i*MEMORY_WIDTH +: MEMORY_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/apb_slave_mem_responder.sv
// APB4 completer: decodes one pselx bit, inserts programmable wait states and
// services strobed writes / reads against a local byte memory.
module apb_slave_mem_responder #(
    parameter int ADDRESS_WIDTH = apb_slave_mem_responder_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = apb_slave_mem_responder_pkg::DATA_WIDTH,
    parameter int NO_OF_SLAVES  = 4,
    parameter int SLAVE_ID      = 0,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = 32'h0000_1000,
    parameter int SLAVE_MEMORY_SIZE = apb_slave_mem_responder_pkg::SLAVE_MEMORY_SIZE
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [NO_OF_SLAVES-1:0]  pselx,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDRESS_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0]    pwdata,
    input  logic [DATA_WIDTH/8-1:0]  pstrb,
    input  logic [2:0]               pprot,
    input  logic [3:0]               wait_states,
    output logic                     pready,
    output logic [DATA_WIDTH-1:0]    prdata,
    output logic                     pslverr,
    output logic                     state_dbg
);
    import apb_slave_mem_responder_pkg::*;

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int MEM_BYTES = SLAVE_MEMORY_SIZE * 1024;
    localparam int MEM_AW    = $clog2(MEM_BYTES);
    localparam int AXW       = ADDRESS_WIDTH + 1;

    // Handshake: a transfer starts with a setup cycle (sel=1, penable=0); the
    // requester then holds sel=1, penable=1 and all controls stable until it
    // samples pready=1, which completes the transfer on that clock edge.

    apb_slave_state_e state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    sel;
    logic                    setup;
    logic                    commit;
    logic                    pready_c;

    logic                    wr_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BYTES-1:0]        strb_q;
    logic [MEM_AW-1:0]       offset_q;
    logic [2:0]              prot_q;

    logic [AXW-1:0]          addr_ext;
    logic [AXW-1:0]          aligned_ext;
    logic [AXW-1:0]          base_ext;
    logic [AXW-1:0]          limit_ext;
    logic [AXW-1:0]          offset_full;
    logic                    err_d;
    logic                    wr_d;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    slave_error_e            err_resp;
    logic                    unused_bits;

    assign sel = pselx[SLAVE_ID];

    // Address decode in one extra bit so the end-of-window sum cannot wrap.
    assign addr_ext    = {1'b0, paddr};
    assign aligned_ext = addr_ext & ~AXW'(BYTES - 1);
    assign base_ext    = {1'b0, BASE_ADDR};
    assign limit_ext   = base_ext + AXW'(MEM_BYTES);
    assign offset_full = aligned_ext - base_ext;
    assign err_d       = (addr_ext < base_ext) | ((aligned_ext + AXW'(BYTES)) > limit_ext);
    assign wr_d        = (tx_type_e'(pwrite) == TX_WRITE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        setup    = 1'b0;
        commit   = 1'b0;
        pready_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel && !penable) begin
                    setup   = 1'b1;
                    cnt_d   = wait_states;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!(sel && penable)) begin
                    // Requester dropped the transfer: abandon without writing.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    pready_c = 1'b1;
                    commit   = wr_q && !err_q;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            offset_q <= '0;
            prot_q   <= '0;
        end else if (setup) begin
            wr_q     <= wr_d;
            err_q    <= err_d;
            wdata_q  <= pwdata;
            strb_q   <= pstrb;
            offset_q <= offset_full[MEM_AW-1:0];
            prot_q   <= pprot;
        end
    end

    apb_slave_byte_memory #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_BYTES  (MEM_BYTES),
        .MEM_AW     (MEM_AW)
    ) u_mem (
        .clk   (pclk),
        .rst   (preset),
        .rd_en (setup && !err_d),
        .raddr (offset_full[MEM_AW-1:0]),
        .rdata (mem_rdata),
        .we    (commit),
        .waddr (offset_q),
        .wdata (wdata_q),
        .wstrb (strb_q)
    );

    assign err_resp  = (pready_c && err_q) ? SLV_ERROR : SLV_OKAY;
    assign pready    = pready_c;
    assign pslverr   = err_resp;
    assign prdata    = (state_q == ACCESS && !err_q) ? mem_rdata : '0;
    assign state_dbg = state_q;

    // Protection bits are recorded but never checked; other selects are not ours.
    assign unused_bits = ^{pselx, prot_q, offset_full[AXW-1:MEM_AW]};

endmodule
